// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers after ID, selects forwarding sources,
// stalls on load-use and steers IF/ID and ID/EXE. Optional counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned NUM_STG  = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned RA_W     = 5,
  localparam int unsigned SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [RA_W-1:0]    id_rs1_addr_i,
  input  logic [RA_W-1:0]    id_rs2_addr_i,
  input  logic               id_rs1_re_i,
  input  logic               id_rs2_re_i,
  input  logic [RA_W-1:0]    id_rd_addr_i,
  input  logic               id_rd_we_i,
  input  logic               id_mem_re_i,
  input  logic               redirect_i,
  input  logic               ext_stall_i,
  output logic               if_stall_o,
  output logic [1:0]         if_id_mode_o,
  output logic [1:0]         id_exe_mode_o,
  output logic               pc_we_o,
  output logic [SEL_W-1:0]   fwd_rs1_sel_o,
  output logic [SEL_W-1:0]   fwd_rs2_sel_o,
  output logic [NUM_STG-1:0] stg_valid_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_flush_cnt_o
`endif
);

  localparam logic [1:0] ModeNormal = 2'b00;
  localparam logic [1:0] ModeStall  = 2'b01;
  localparam logic [1:0] ModeFlush  = 2'b10;

  logic [NUM_STG-1:0]           valid_q, valid_d;
  logic [NUM_STG-1:0]           we_q, we_d;
  logic [NUM_STG-1:0]           ld_q, ld_d;
  logic [NUM_STG-1:0][RA_W-1:0] rd_q, rd_d;

  logic [NUM_STG-1:0] rs1_hit, rs2_hit;
  logic [SEL_W-1:0]   rs1_sel, rs2_sel;
  logic               rs1_ld_haz, rs2_ld_haz;
  logic               hazard;

  always_comb begin
    rs1_hit = '0;
    rs2_hit = '0;
    for (int k = 0; k < int'(NUM_STG); k++) begin
      rs1_hit[k] = valid_q[k] && we_q[k] && (rd_q[k] != '0) && id_rs1_re_i &&
                   (rd_q[k] == id_rs1_addr_i);
      rs2_hit[k] = valid_q[k] && we_q[k] && (rd_q[k] != '0) && id_rs2_re_i &&
                   (rd_q[k] == id_rs2_addr_i);
    end
  end

  // Walk oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    rs1_sel    = '0;
    rs2_sel    = '0;
    rs1_ld_haz = 1'b0;
    rs2_ld_haz = 1'b0;
    for (int k = int'(NUM_STG) - 1; k >= 0; k--) begin
      if (rs1_hit[k]) begin
        rs1_sel    = SEL_W'(k + 1);
        rs1_ld_haz = ld_q[k] && (k <= int'(LOAD_LAT));
      end
      if (rs2_hit[k]) begin
        rs2_sel    = SEL_W'(k + 1);
        rs2_ld_haz = ld_q[k] && (k <= int'(LOAD_LAT));
      end
    end
  end

  assign hazard = id_valid_i && (rs1_ld_haz || rs2_ld_haz);

  always_comb begin
    if_stall_o    = 1'b0;
    if_id_mode_o  = ModeNormal;
    id_exe_mode_o = ModeNormal;
    pc_we_o       = 1'b0;
    fwd_rs1_sel_o = rs1_sel;
    fwd_rs2_sel_o = rs2_sel;
    stg_valid_o   = valid_q;
    if (rst_i) begin
      if_id_mode_o  = ModeFlush;
      id_exe_mode_o = ModeFlush;
      fwd_rs1_sel_o = '0;
      fwd_rs2_sel_o = '0;
      stg_valid_o   = '0;
    end else if (ext_stall_i) begin
      if_stall_o    = 1'b1;
      if_id_mode_o  = ModeStall;
      id_exe_mode_o = ModeStall;
    end else if (hazard) begin
      if_stall_o    = 1'b1;
      if_id_mode_o  = ModeStall;
      id_exe_mode_o = ModeFlush;
    end else begin
      pc_we_o       = redirect_i && id_valid_i;
      if_id_mode_o  = pc_we_o ? ModeFlush : ModeNormal;
    end
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    if (!ext_stall_i) begin
      for (int k = 1; k < int'(NUM_STG); k++) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        ld_d[k]    = ld_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (hazard) begin
        valid_d[0] = 1'b0;
        we_d[0]    = 1'b0;
        ld_d[0]    = 1'b0;
        rd_d[0]    = '0;
      end else begin
        valid_d[0] = id_valid_i;
        we_d[0]    = id_rd_we_i && id_valid_i;
        ld_d[0]    = id_mem_re_i;
        rd_d[0]    = id_rd_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      we_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!ext_stall_i && hazard && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (pc_we_o && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
